// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave: register map, bit positions, FSM states.
package spi_slave_pkg;

  localparam logic [2:0] ADR_SPCR  = 3'b000;
  localparam logic [2:0] ADR_SPSR  = 3'b001;
  localparam logic [2:0] ADR_DATA  = 3'b010;
  localparam logic [2:0] ADR_DUMMY = 3'b011;

  localparam int SPCR_SPIE = 7;
  localparam int SPCR_SPE  = 6;
  localparam int SPCR_CPOL = 3;
  localparam int SPCR_CPHA = 2;

  localparam int SPSR_SPIF = 7;
  localparam int SPSR_WCOL = 6;
  localparam int SPSR_ROVR = 5;
  localparam int SPSR_TUND = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/fifo4.sv
// Four-entry first-word-fall-through FIFO; same-cycle read and write both honoured.
module fifo4 #(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [DW-1:0] din_i,
  input  logic          re_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DW-1:0] mem_q [4];
  logic [1:0]    wp_q, rp_q;
  logic [2:0]    cnt_q;
  logic          do_we, do_re;

  assign full_o  = (cnt_q == 3'd4);
  assign empty_o = (cnt_q == 3'd0);
  assign do_we   = we_i & ~full_o;
  assign do_re   = re_i & ~empty_o;
  // Head entry is visible without a read cycle; an empty read shows stale data.
  assign dout_o  = mem_q[rp_q];

  // Storage array, written only when there is room.
  always_ff @(posedge clk_i) begin
    if (do_we) mem_q[wp_q] <= din_i;
  end

  // Pointers and occupancy; clear discards everything.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_we) wp_q <= wp_q + 2'd1;
      if (do_re) rp_q <= rp_q + 2'd1;
      cnt_q <= cnt_q + {2'b00, do_we} - {2'b00, do_re};
    end
  end

endmodule

// File: rtl/spi_slave_sync.sv
// Synchronizes the asynchronous SPI pins and detects SCK and SS edges.
module spi_slave_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sck_i,
  input  logic ss_n_i,
  input  logic mosi_i,
  output logic mosi_s_o,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic ss_fall_o,
  output logic ss_rise_o
);

  logic [SYNC_STAGES-1:0] sck_q, ss_q, mosi_q;
  logic                   sck_d1_q, ss_d1_q;
  logic                   sck_s, ss_s;

  assign sck_s      = sck_q[SYNC_STAGES-1];
  assign ss_s       = ss_q[SYNC_STAGES-1];
  assign mosi_s_o   = mosi_q[SYNC_STAGES-1];
  assign sck_rise_o = sck_s & ~sck_d1_q;
  assign sck_fall_o = ~sck_s & sck_d1_q;
  assign ss_fall_o  = ~ss_s & ss_d1_q;
  assign ss_rise_o  = ss_s & ~ss_d1_q;

  // Synchronizer chains plus one delay flop for edge detection; SS resets deasserted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_q    <= '0;
      ss_q     <= '1;
      mosi_q   <= '0;
      sck_d1_q <= 1'b0;
      ss_d1_q  <= 1'b1;
    end else begin
      sck_q    <= {sck_q[SYNC_STAGES-2:0], sck_i};
      ss_q     <= {ss_q[SYNC_STAGES-2:0], ss_n_i};
      mosi_q   <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
      sck_d1_q <= sck_s;
      ss_d1_q  <= ss_s;
    end
  end

endmodule

// File: rtl/simple_spi_slave.sv
// SPI slave with an 8-bit WISHBONE register interface and 4-deep TX/RX FIFOs.
module simple_spi_slave
  import spi_slave_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DUMMY_RST   = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic [2:0] adr_i,
  input  logic       we_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  output logic       inta_o,
  input  logic       sck_i,
  input  logic       ss_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o
);

  logic       spie_q, spe_q, cpol_q, cpha_q;
  logic [7:0] dummy_q;
  logic       spif_q, wcol_q, rovr_q, tund_q;
  logic       ack_q, inta_q;
  logic [7:0] dat_q, rdata;
  state_e     state_q, state_d;
  logic [7:0] treg_q, treg_d, rreg_q, rreg_d;
  logic [2:0] bcnt_q, bcnt_d;

  logic mosi_s, sck_rise, sck_fall, ss_fall, ss_rise;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic acc, wr, rd, w1c, tx_push, wcol_set, rx_pop;
  logic tx_pop, rx_push, set_spif, set_rovr, set_tund;
  logic [7:0] tx_dout, rx_dout;
  logic tx_full, tx_empty, rx_full, rx_empty;

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .sck_i      (sck_i),
    .ss_n_i     (ss_n_i),
    .mosi_i     (mosi_i),
    .mosi_s_o   (mosi_s),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .ss_fall_o  (ss_fall),
    .ss_rise_o  (ss_rise)
  );

  fifo4 #(.DW(8)) u_tx_fifo (
    .clk_i (clk_i), .rst_i (rst_i), .clr_i (~spe_q),
    .we_i (tx_push), .din_i (dat_i), .re_i (tx_pop),
    .dout_o (tx_dout), .full_o (tx_full), .empty_o (tx_empty)
  );

  fifo4 #(.DW(8)) u_rx_fifo (
    .clk_i (clk_i), .rst_i (rst_i), .clr_i (~spe_q),
    .we_i (rx_push), .din_i ({rreg_q[6:0], mosi_s}), .re_i (rx_pop),
    .dout_o (rx_dout), .full_o (rx_full), .empty_o (rx_empty)
  );

  // Bus decode: one access per strobe, FIFO side effects only on the acked cycle.
  assign acc      = cyc_i & stb_i & ~ack_q;
  assign wr       = acc & we_i;
  assign rd       = acc & ~we_i;
  assign w1c      = wr & (adr_i == ADR_SPSR);
  assign tx_push  = wr & (adr_i == ADR_DATA) & ~tx_full;
  assign wcol_set = wr & (adr_i == ADR_DATA) & tx_full;
  assign rx_pop   = rd & (adr_i == ADR_DATA) & ~rx_empty;

  assign lead_edge   = cpol_q ? sck_fall : sck_rise;
  assign trail_edge  = cpol_q ? sck_rise : sck_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  assign dat_o     = dat_q;
  assign ack_o     = ack_q;
  assign inta_o    = inta_q;
  assign miso_oe_o = (state_q != IDLE);
  assign miso_o    = (state_q == SHIFT) & treg_q[7];

  // Register read mux.
  always_comb begin
    rdata = 8'h00;
    case (adr_i)
      ADR_SPCR:  rdata = {spie_q, spe_q, 2'b00, cpol_q, cpha_q, 2'b00};
      ADR_SPSR:  rdata = {spif_q, wcol_q, rovr_q, tund_q, tx_full, tx_empty, rx_full, rx_empty};
      ADR_DATA:  rdata = rx_dout;
      ADR_DUMMY: rdata = dummy_q;
      default:   rdata = 8'h00;
    endcase
  end

  // Transfer FSM next state and shift-register updates.
  always_comb begin
    state_d  = state_q;
    treg_d   = treg_q;
    rreg_d   = rreg_q;
    bcnt_d   = bcnt_q;
    tx_pop   = 1'b0;
    rx_push  = 1'b0;
    set_spif = 1'b0;
    set_rovr = 1'b0;
    set_tund = 1'b0;
    if (!spe_q || ss_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (ss_fall) state_d = LOAD;
        LOAD: begin
          if (tx_empty) begin
            treg_d   = dummy_q;
            set_tund = 1'b1;
          end else begin
            treg_d = tx_dout;
            tx_pop = 1'b1;
          end
          bcnt_d  = 3'd0;
          state_d = SHIFT;
        end
        SHIFT: begin
          if (sample_edge) begin
            rreg_d = {rreg_q[6:0], mosi_s};
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
              rx_push  = 1'b1;
              set_spif = 1'b1;
              set_rovr = rx_full;
              state_d  = LOAD;
            end
          end
          // No shift while bcnt is 0: with cpha=1 that lead edge presents bit 7,
          // with cpha=0 it is the trailing edge of the previous byte, which must not
          // disturb the freshly loaded byte.
          if (shift_edge && (bcnt_q != 3'd0)) treg_d = {treg_q[6:0], 1'b0};
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM and shift registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      treg_q  <= 8'h00;
      rreg_q  <= 8'h00;
      bcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      treg_q  <= treg_d;
      rreg_q  <= rreg_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Bus handshake, control registers, status flags (set beats clear) and interrupt.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q   <= 1'b0;
      dat_q   <= 8'h00;
      inta_q  <= 1'b0;
      spie_q  <= 1'b0;
      spe_q   <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      dummy_q <= DUMMY_RST;
      spif_q  <= 1'b0;
      wcol_q  <= 1'b0;
      rovr_q  <= 1'b0;
      tund_q  <= 1'b0;
    end else begin
      ack_q  <= acc;
      inta_q <= spie_q & (spif_q | rovr_q | tund_q);
      if (acc) dat_q <= rdata;
      if (wr && adr_i == ADR_SPCR) begin
        spie_q <= dat_i[SPCR_SPIE];
        spe_q  <= dat_i[SPCR_SPE];
        cpol_q <= dat_i[SPCR_CPOL];
        cpha_q <= dat_i[SPCR_CPHA];
      end
      if (wr && adr_i == ADR_DUMMY) dummy_q <= dat_i;
      if (!spe_q) begin
        spif_q <= 1'b0;
        wcol_q <= 1'b0;
        rovr_q <= 1'b0;
        tund_q <= 1'b0;
      end else begin
        spif_q <= set_spif | (spif_q & ~(w1c & dat_i[SPSR_SPIF]));
        wcol_q <= wcol_set | (wcol_q & ~(w1c & dat_i[SPSR_WCOL]));
        rovr_q <= set_rovr | (rovr_q & ~(w1c & dat_i[SPSR_ROVR]));
        tund_q <= set_tund | (tund_q & ~(w1c & dat_i[SPSR_TUND]));
      end
    end
  end

endmodule

// File: tb/tb_simple_spi_slave.sv
// Directed bench: WB register access plus a behavioural SPI master.
module tb_simple_spi_slave;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [2:0] adr_i = 3'd0;
  logic [7:0] dat_i = 8'h00;
  logic [7:0] dat_o;
  logic       ack_o, inta_o;
  logic       sck_i = 1'b0, ss_n_i = 1'b1, mosi_i = 1'b0;
  logic       miso_o, miso_oe_o;

  int total = 0;
  int bad   = 0;
  logic cpol_m = 1'b0, cpha_m = 1'b0;
  localparam int HP = 8;  // SCK half period in clk cycles

  simple_spi_slave #(.SYNC_STAGES(2), .DUMMY_RST(8'hFF)) dut (
    .clk_i (clk_i), .rst_i (rst_i),
    .cyc_i (cyc_i), .stb_i (stb_i), .adr_i (adr_i), .we_i (we_i),
    .dat_i (dat_i), .dat_o (dat_o), .ack_o (ack_o), .inta_o (inta_o),
    .sck_i (sck_i), .ss_n_i (ss_n_i), .mosi_i (mosi_i),
    .miso_o (miso_o), .miso_oe_o (miso_oe_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic clks(input int n);
    repeat (n) @(posedge clk_i);
  endtask

  task automatic wb_xfer(input logic w, input logic [2:0] a, input logic [7:0] d,
                         output logic [7:0] q);
    bit got = 0;
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk_i);
      if (ack_o) got = 1;
    end
    q = dat_o;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    if (!got) begin
      bad++;
      total++;
      $display("FAIL wb_ack_timeout adr=%0d ack=%b required=1", a, ack_o);
    end
  endtask

  task automatic wb_wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] q;
    wb_xfer(1'b1, a, d, q);
  endtask

  task automatic wb_rd(input logic [2:0] a, output logic [7:0] q);
    wb_xfer(1'b0, a, 8'h00, q);
  endtask

  task automatic spi_begin();
    sck_i = cpol_m;
    ss_n_i = 1'b0;
    clks(2 * HP);
  endtask

  task automatic spi_end();
    clks(HP);
    ss_n_i = 1'b1;
    sck_i = cpol_m;
    clks(2 * HP);
  endtask

  // Master shifts n bits MSB-first; returns bits received from the slave.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (!cpha_m) begin
        mosi_i = tx[7-i];
        clks(HP);
        rx = {rx[6:0], miso_o};
        sck_i = ~cpol_m;
        clks(HP);
        sck_i = cpol_m;
      end else begin
        sck_i = ~cpol_m;
        mosi_i = tx[7-i];
        clks(HP);
        rx = {rx[6:0], miso_o};
        sck_i = cpol_m;
        clks(HP);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] q;
    clks(3);
    #1;
    total++;
    if ({dat_o, ack_o, inta_o, miso_o, miso_oe_o} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs got=%h required=000", {dat_o, ack_o, inta_o, miso_o, miso_oe_o});
    end
    @(negedge clk_i); rst_i = 1'b0;
    wb_rd(3'b000, q); total++;
    if (q !== 8'h00) begin bad++; $display("FAIL reset_spcr got=%h required=00", q); end
    wb_rd(3'b011, q); total++;
    if (q !== 8'hFF) begin bad++; $display("FAIL reset_dummy got=%h required=FF", q); end
    wb_rd(3'b001, q); total++;
    if (q !== 8'h05) begin bad++; $display("FAIL reset_spsr got=%h required=05", q); end
    wb_rd(3'b100, q); total++;
    if (q !== 8'h00) begin bad++; $display("FAIL reset_hiadr got=%h required=00", q); end
    $display("test_reset done");
  endtask

  task automatic test_mode0();
    logic [7:0] q, m;
    cpol_m = 0; cpha_m = 0;
    wb_wr(3'b000, 8'hC0);
    wb_wr(3'b010, 8'hA5);
    spi_begin();
    total++;
    if (miso_oe_o !== 1'b1) begin bad++; $display("FAIL t1_oe got=%b required=1", miso_oe_o); end
    spi_bits(8'h3C, 8, m);
    spi_end();
    total++;
    if (m !== 8'hA5) begin bad++; $display("FAIL t1_miso got=%h required=A5", m); end
    total++;
    if (miso_oe_o !== 1'b0) begin bad++; $display("FAIL t1_oe_idle got=%b required=0", miso_oe_o); end
    total++;
    if (inta_o !== 1'b1) begin bad++; $display("FAIL t1_inta got=%b required=1", inta_o); end
    wb_rd(3'b001, q); total++;
    if (q !== 8'h94) begin bad++; $display("FAIL t1_spsr got=%h required=94", q); end
    wb_rd(3'b010, q); total++;
    if (q !== 8'h3C) begin bad++; $display("FAIL t1_rx got=%h required=3C", q); end
    wb_rd(3'b001, q); total++;
    if (q !== 8'h95) begin bad++; $display("FAIL t1_spsr_pop got=%h required=95", q); end
    wb_wr(3'b001, 8'h90);
    wb_rd(3'b001, q); total++;
    if (q !== 8'h05) begin bad++; $display("FAIL t1_w1c got=%h required=05", q); end
    total++;
    if (inta_o !== 1'b0) begin bad++; $display("FAIL t1_inta_clr got=%b required=0", inta_o); end
    $display("test_mode0 master_rx=%h", m);
  endtask

  task automatic test_back_to_back();
    logic [7:0] q, m;
    logic [7:0] pat [4];
    pat[0] = 8'h01; pat[1] = 8'h02; pat[2] = 8'h04; pat[3] = 8'h08;
    for (int md = 1; md < 4; md++) begin
      cpol_m = md[1]; cpha_m = md[0];
      sck_i = cpol_m;
      wb_wr(3'b000, 8'h00);
      wb_wr(3'b000, {2'b01, 2'b00, cpol_m, cpha_m, 2'b00});
      for (int i = 0; i < 4; i++) wb_wr(3'b010, pat[i]);
      spi_begin();
      for (int i = 0; i < 4; i++) begin
        spi_bits(pat[i], 8, m);
        total++;
        if (m !== pat[i]) begin bad++; $display("FAIL t2_miso mode=%0d byte=%0d got=%h required=%h", md, i, m, pat[i]); end
      end
      spi_end();
      wb_rd(3'b001, q); total++;
      if (q !== 8'h96) begin bad++; $display("FAIL t2_spsr mode=%0d got=%h required=96", md, q); end
      for (int i = 0; i < 4; i++) begin
        wb_rd(3'b010, q); total++;
        if (q !== pat[i]) begin bad++; $display("FAIL t2_rx mode=%0d byte=%0d got=%h required=%h", md, i, q, pat[i]); end
      end
      $display("test_back_to_back mode=%0d done", md);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] q, m;
    cpol_m = 0; cpha_m = 0; sck_i = 0;
    wb_wr(3'b000, 8'h00);
    wb_wr(3'b000, 8'h40);
    wb_wr(3'b011, 8'h5A);
    spi_begin();
    spi_bits(8'hC1, 8, m);
    spi_end();
    total++;
    if (m !== 8'h5A) begin bad++; $display("FAIL t3_dummy got=%h required=5A", m); end
    wb_rd(3'b001, q); total++;
    if (q !== 8'h94) begin bad++; $display("FAIL t3_tund got=%h required=94", q); end
    wb_wr(3'b001, 8'h10);
    wb_rd(3'b001, q); total++;
    if (q !== 8'h84) begin bad++; $display("FAIL t3_w1c got=%h required=84", q); end
    $display("test_underrun master_rx=%h", m);
  endtask

  task automatic test_overrun();
    logic [7:0] q, m;
    logic [7:0] txp [5];
    logic [7:0] mexp [5];
    txp[0] = 8'hA1; txp[1] = 8'hA2; txp[2] = 8'hA3; txp[3] = 8'hA4; txp[4] = 8'hA5;
    mexp[0] = 8'h11; mexp[1] = 8'h22; mexp[2] = 8'h33; mexp[3] = 8'h44; mexp[4] = 8'hC3;
    wb_wr(3'b000, 8'h00);
    wb_wr(3'b000, 8'h40);
    wb_wr(3'b011, 8'hC3);
    for (int i = 0; i < 4; i++) wb_wr(3'b010, mexp[i]);
    wb_wr(3'b010, 8'h55);
    wb_rd(3'b001, q); total++;
    if (q !== 8'h49) begin bad++; $display("FAIL t4_wcol got=%h required=49", q); end
    spi_begin();
    for (int i = 0; i < 5; i++) begin
      spi_bits(txp[i], 8, m);
      total++;
      if (m !== mexp[i]) begin bad++; $display("FAIL t4_miso byte=%0d got=%h required=%h", i, m, mexp[i]); end
    end
    spi_end();
    wb_rd(3'b001, q); total++;
    if (q !== 8'hF6) begin bad++; $display("FAIL t4_rovr got=%h required=F6", q); end
    for (int i = 0; i < 4; i++) begin
      wb_rd(3'b010, q); total++;
      if (q !== txp[i]) begin bad++; $display("FAIL t4_rx byte=%0d got=%h required=%h", i, q, txp[i]); end
    end
    $display("test_overrun done");
  endtask

  task automatic test_abort();
    logic [7:0] q, m;
    wb_wr(3'b000, 8'h00);
    wb_wr(3'b000, 8'h40);
    wb_wr(3'b010, 8'h96);
    spi_begin();
    spi_bits(8'hFF, 3, m);
    spi_end();
    wb_rd(3'b001, q); total++;
    if (q !== 8'h05) begin bad++; $display("FAIL t5_partial got=%h required=05", q); end
    wb_wr(3'b010, 8'h69);
    spi_begin();
    spi_bits(8'hE7, 8, m);
    spi_end();
    total++;
    if (m !== 8'h69) begin bad++; $display("FAIL t5_miso got=%h required=69", m); end
    wb_rd(3'b010, q); total++;
    if (q !== 8'hE7) begin bad++; $display("FAIL t5_rx got=%h required=E7", q); end
    wb_wr(3'b010, 8'h12);
    wb_wr(3'b010, 8'h34);
    spi_begin();
    spi_bits(8'hAA, 4, m);
    wb_wr(3'b000, 8'h00);
    clks(2);
    total++;
    if (miso_oe_o !== 1'b0) begin bad++; $display("FAIL t5_spe_oe got=%b required=0", miso_oe_o); end
    wb_rd(3'b001, q); total++;
    if (q !== 8'h05) begin bad++; $display("FAIL t5_spe_spsr got=%h required=05", q); end
    spi_end();
    $display("test_abort done");
  endtask

  task automatic test_async_reset();
    logic [7:0] q, m;
    wb_wr(3'b000, 8'hC0);
    wb_wr(3'b011, 8'h77);
    wb_wr(3'b010, 8'hAA);
    wb_rd(3'b011, q);
    spi_begin();
    spi_bits(8'h0F, 4, m);
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    total++;
    if ({dat_o, ack_o, inta_o, miso_o, miso_oe_o} !== 12'h000) begin
      bad++;
      $display("FAIL t6_async_outputs got=%h required=000", {dat_o, ack_o, inta_o, miso_o, miso_oe_o});
    end
    clks(2);
    @(negedge clk_i); rst_i = 1'b0;
    spi_end();
    wb_rd(3'b000, q); total++;
    if (q !== 8'h00) begin bad++; $display("FAIL t6_spcr got=%h required=00", q); end
    wb_rd(3'b011, q); total++;
    if (q !== 8'hFF) begin bad++; $display("FAIL t6_dummy got=%h required=FF", q); end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_back_to_back();
    test_underrun();
    test_overrun();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
